// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: register-index bus, FSM state and
// PC redirect encodings.
package pipe_ctrl_pkg;

  localparam int unsigned REG_INDEX_W = 5;
  localparam int unsigned DRAIN_CNT_W = 4;

  typedef logic [REG_INDEX_W-1:0] reg_index_t;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_TRAP_DRAIN = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_TRAP   = 2'd2
  } redirect_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and flow/flush controls between the pipeline datapath and
// pipe_ctrl. master = sequencer side, slave = datapath side.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic       if_busy_i;
  reg_index_t id_rs1_index_i;
  logic       id_rs1_en_i;
  reg_index_t id_rs2_index_i;
  logic       id_rs2_en_i;
  reg_index_t ex_rd_index_i;
  logic       ex_rd_en_i;
  logic       ex_inst_load_i;
  logic       ex_branch_taken_i;
  logic       mem_req_i;
  logic       mem_ack_i;
  logic       mem_trap_i;

  logic       if2id_valid_o;
  logic       id2ex_valid_o;
  logic       ex2mem_valid_o;
  logic       mem2wb_valid_o;
  logic       if2id_flush_o;
  logic       id2ex_flush_o;
  logic       ex2mem_flush_o;
  logic       mem2wb_flush_o;
  logic       pc_hold_o;
  logic [1:0] pc_redirect_o;
  logic       mem_wait_o;

  modport master (
    input  if_busy_i, id_rs1_index_i, id_rs1_en_i, id_rs2_index_i, id_rs2_en_i,
           ex_rd_index_i, ex_rd_en_i, ex_inst_load_i, ex_branch_taken_i,
           mem_req_i, mem_ack_i, mem_trap_i,
    output if2id_valid_o, id2ex_valid_o, ex2mem_valid_o, mem2wb_valid_o,
           if2id_flush_o, id2ex_flush_o, ex2mem_flush_o, mem2wb_flush_o,
           pc_hold_o, pc_redirect_o, mem_wait_o
  );

  modport slave (
    output if_busy_i, id_rs1_index_i, id_rs1_en_i, id_rs2_index_i, id_rs2_en_i,
           ex_rd_index_i, ex_rd_en_i, ex_inst_load_i, ex_branch_taken_i,
           mem_req_i, mem_ack_i, mem_trap_i,
    input  if2id_valid_o, id2ex_valid_o, ex2mem_valid_o, mem2wb_valid_o,
           if2id_flush_o, id2ex_flush_o, ex2mem_flush_o, mem2wb_flush_o,
           pc_hold_o, pc_redirect_o, mem_wait_o
  );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use comparator: an EX load whose rd feeds a used ID
// source operand. x0 never creates a dependency.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  reg_index_t id_rs1_index_i,
  input  logic       id_rs1_en_i,
  input  reg_index_t id_rs2_index_i,
  input  logic       id_rs2_en_i,
  input  reg_index_t ex_rd_index_i,
  input  logic       ex_rd_en_i,
  input  logic       ex_inst_load_i,
  output logic       load_use_o
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  assign rs1_hit_s  = id_rs1_en_i & (id_rs1_index_i == ex_rd_index_i);
  assign rs2_hit_s  = id_rs2_en_i & (id_rs2_index_i == ex_rd_index_i);
  assign load_use_o = ex_inst_load_i & ex_rd_en_i
                    & (ex_rd_index_i != reg_index_t'(5'd0))
                    & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: hazard priority, memory wait and trap drain.
// Define PIPE_CTRL_PERF_EN to add the stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TRAP_DRAIN_CYCLES = 2
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int unsigned PERF_W = 32
`endif
)(
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.master pif
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles_o,
  output logic [PERF_W-1:0] flush_events_o
`endif
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(TRAP_DRAIN_CYCLES - 1);

  ctrl_state_e            state_r;
  ctrl_state_e            state_nxt_s;
  logic [DRAIN_CNT_W-1:0] drain_cnt_r;
  logic [DRAIN_CNT_W-1:0] drain_cnt_nxt_s;

  logic       mem_stall_s;
  logic       load_use_s;
  // Bit order for valid/flush vectors: {mem2wb, ex2mem, id2ex, if2id}
  logic [3:0] valid_s;
  logic [3:0] flush_s;
  logic       pc_hold_s;
  redirect_e  redirect_s;
  logic       mem_wait_s;

  assign mem_stall_s = pif.mem_req_i & ~pif.mem_ack_i;

  pipe_hazard_detect u_hazard (
    .id_rs1_index_i (pif.id_rs1_index_i),
    .id_rs1_en_i    (pif.id_rs1_en_i),
    .id_rs2_index_i (pif.id_rs2_index_i),
    .id_rs2_en_i    (pif.id_rs2_en_i),
    .ex_rd_index_i  (pif.ex_rd_index_i),
    .ex_rd_en_i     (pif.ex_rd_en_i),
    .ex_inst_load_i (pif.ex_inst_load_i),
    .load_use_o     (load_use_s)
  );

  // FSM state and drain counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      drain_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
    end
  end

  // Next-state logic; the ack cycle of MEM_WAIT is decided like a RUN cycle
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    case (state_r)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall_s) begin
          state_nxt_s = ST_MEM_WAIT;
        end else if (pif.mem_trap_i) begin
          state_nxt_s     = ST_TRAP_DRAIN;
          drain_cnt_nxt_s = DRAIN_LOAD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_TRAP_DRAIN: begin
        if (pif.mem_trap_i) begin
          drain_cnt_nxt_s = DRAIN_LOAD;
        end else if (drain_cnt_r == 4'd0) begin
          state_nxt_s = ST_RUN;
        end else begin
          drain_cnt_nxt_s = drain_cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s     = ST_RUN;
        drain_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // Flow/flush decode in strict hazard priority order
  always_comb begin
    valid_s    = 4'b1111;
    flush_s    = 4'b0000;
    pc_hold_s  = 1'b0;
    redirect_s = REDIR_NONE;
    mem_wait_s = 1'b0;
    if (rst) begin
      valid_s   = 4'b0000;
      pc_hold_s = 1'b1;
    end else if (state_r == ST_TRAP_DRAIN) begin
      flush_s = 4'b0111;
    end else if (mem_stall_s) begin
      valid_s    = 4'b1000;
      flush_s    = 4'b1000;
      pc_hold_s  = 1'b1;
      mem_wait_s = 1'b1;
    end else if (pif.mem_trap_i) begin
      flush_s    = 4'b0111;
      redirect_s = REDIR_TRAP;
    end else if (pif.ex_branch_taken_i) begin
      flush_s    = 4'b0011;
      redirect_s = REDIR_BRANCH;
    end else if (load_use_s) begin
      valid_s   = 4'b1110;
      flush_s   = 4'b0010;
      pc_hold_s = 1'b1;
    end else if (pif.if_busy_i) begin
      flush_s   = 4'b0001;
      pc_hold_s = 1'b1;
    end else begin
      valid_s = 4'b1111;
    end
  end

  assign pif.if2id_valid_o  = valid_s[0];
  assign pif.id2ex_valid_o  = valid_s[1];
  assign pif.ex2mem_valid_o = valid_s[2];
  assign pif.mem2wb_valid_o = valid_s[3];
  assign pif.if2id_flush_o  = flush_s[0];
  assign pif.id2ex_flush_o  = flush_s[1];
  assign pif.ex2mem_flush_o = flush_s[2];
  assign pif.mem2wb_flush_o = flush_s[3];
  assign pif.pc_hold_o      = pc_hold_s;
  assign pif.pc_redirect_o  = redirect_s;
  assign pif.mem_wait_o     = mem_wait_s;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cycles_r;
  logic [PERF_W-1:0] flush_events_r;

  // Only mem-stall and load-use hold if2id outside reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_r <= {PERF_W{1'b0}};
      flush_events_r <= {PERF_W{1'b0}};
    end else begin
      if (!valid_s[0]) begin
        stall_cycles_r <= stall_cycles_r + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (redirect_s != REDIR_NONE) begin
        flush_events_r <= flush_events_r + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
        flush_events_r <= flush_events_r;
      end
    end
  end

  assign stall_cycles_o = stall_cycles_r;
  assign flush_events_o = flush_events_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected control vectors are queued as each
// cycle's stimulus is driven and compared on the falling edge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic rst;
  pipe_ctrl_if pif ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_events_o;
`endif

  pipe_ctrl #(.TRAP_DRAIN_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif.master)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles_o (stall_cycles_o),
    .flush_events_o (flush_events_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid[3:0], flush[3:0], pc_hold, redirect[1:0], mem_wait}; nibbles are {mem2wb,ex2mem,id2ex,if2id}
  localparam logic [11:0] E_RST    = {4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0};
  localparam logic [11:0] E_RUN    = {4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
  localparam logic [11:0] E_MSTALL = {4'b1000, 4'b1000, 1'b1, 2'd0, 1'b1};
  localparam logic [11:0] E_TRAP   = {4'b1111, 4'b0111, 1'b0, 2'd2, 1'b0};
  localparam logic [11:0] E_DRAIN  = {4'b1111, 4'b0111, 1'b0, 2'd0, 1'b0};
  localparam logic [11:0] E_BR     = {4'b1111, 4'b0011, 1'b0, 2'd1, 1'b0};
  localparam logic [11:0] E_LU     = {4'b1110, 4'b0010, 1'b1, 2'd0, 1'b0};
  localparam logic [11:0] E_IFB    = {4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0};

  typedef struct {
    logic       rst;
    logic       if_busy;
    logic [4:0] rs1;
    logic       rs1_en;
    logic [4:0] rs2;
    logic       rs2_en;
    logic [4:0] rd;
    logic       rd_en;
    logic       load;
    logic       br;
    logic       req;
    logic       ack;
    logic       trap;
  } stim_t;

  stim_t       nxt;
  logic [11:0] exp_q[$];
  string       tag_q[$];
  int          chk_cnt;
  int          err_cnt;
  int unsigned exp_stall;
  int unsigned exp_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] observed();
    return {pif.mem2wb_valid_o, pif.ex2mem_valid_o, pif.id2ex_valid_o, pif.if2id_valid_o,
            pif.mem2wb_flush_o, pif.ex2mem_flush_o, pif.id2ex_flush_o, pif.if2id_flush_o,
            pif.pc_hold_o, pif.pc_redirect_o, pif.mem_wait_o};
  endfunction

  task automatic clear_stim();
    nxt = '{rst: 1'b0, if_busy: 1'b0, rs1: 5'd0, rs1_en: 1'b0, rs2: 5'd0, rs2_en: 1'b0,
            rd: 5'd0, rd_en: 1'b0, load: 1'b0, br: 1'b0, req: 1'b0, ack: 1'b0, trap: 1'b0};
  endtask

  // One cycle: drive nxt after the edge, queue its expectation, compare on negedge
  task automatic step(input string tag, input logic [11:0] exp);
    logic [11:0] e;
    string       t;
    @(posedge clk);
    #1;
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall", stall_cycles_o, exp_stall);
    check("perf_flush", flush_events_o, exp_flush);
`endif
    rst                   = nxt.rst;
    pif.if_busy_i         = nxt.if_busy;
    pif.id_rs1_index_i    = nxt.rs1;
    pif.id_rs1_en_i       = nxt.rs1_en;
    pif.id_rs2_index_i    = nxt.rs2;
    pif.id_rs2_en_i       = nxt.rs2_en;
    pif.ex_rd_index_i     = nxt.rd;
    pif.ex_rd_en_i        = nxt.rd_en;
    pif.ex_inst_load_i    = nxt.load;
    pif.ex_branch_taken_i = nxt.br;
    pif.mem_req_i         = nxt.req;
    pif.mem_ack_i         = nxt.ack;
    pif.mem_trap_i        = nxt.trap;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {20'd0, observed()}, {20'd0, e});
      if (e == E_RST) begin
        exp_stall = 0;
        exp_flush = 0;
      end else begin
        if (e == E_MSTALL || e == E_LU) exp_stall = exp_stall + 1;
        if (e == E_TRAP || e == E_BR) exp_flush = exp_flush + 1;
      end
    end
    clear_stim();
  endtask

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    exp_stall = 0;
    exp_flush = 0;
    clear_stim();
    rst = 1'b1;
    pif.if_busy_i = 1'b0; pif.id_rs1_index_i = 5'd0; pif.id_rs1_en_i = 1'b0;
    pif.id_rs2_index_i = 5'd0; pif.id_rs2_en_i = 1'b0; pif.ex_rd_index_i = 5'd0;
    pif.ex_rd_en_i = 1'b0; pif.ex_inst_load_i = 1'b0; pif.ex_branch_taken_i = 1'b0;
    pif.mem_req_i = 1'b0; pif.mem_ack_i = 1'b0; pif.mem_trap_i = 1'b0;

    nxt.rst = 1'b1; nxt.req = 1'b1; nxt.br = 1'b1; step("reset_a", E_RST);
    nxt.rst = 1'b1; step("reset_b", E_RST);
    step("idle", E_RUN);

    nxt.load = 1'b1; nxt.rd = 5'd5; nxt.rd_en = 1'b1; nxt.rs2 = 5'd5; nxt.rs2_en = 1'b1;
    step("lu_rs2", E_LU);
    nxt.load = 1'b1; nxt.rd = 5'd0; nxt.rd_en = 1'b1; nxt.rs2 = 5'd0; nxt.rs2_en = 1'b1;
    step("lu_x0", E_RUN);
    nxt.load = 1'b1; nxt.rd = 5'd17; nxt.rd_en = 1'b1; nxt.rs1 = 5'd17; nxt.rs1_en = 1'b1;
    step("lu_rs1", E_LU);
    nxt.load = 1'b1; nxt.rd = 5'd17; nxt.rd_en = 1'b1; nxt.rs1 = 5'd17;
    step("lu_rs1_unused", E_RUN);
    nxt.load = 1'b0; nxt.rd = 5'd9; nxt.rd_en = 1'b1; nxt.rs1 = 5'd9; nxt.rs1_en = 1'b1;
    step("lu_not_load", E_RUN);
    nxt.if_busy = 1'b1; step("if_busy", E_IFB);

    nxt.req = 1'b1; step("mstall_c1", E_MSTALL);
    nxt.req = 1'b1; nxt.if_busy = 1'b1; step("mstall_c2", E_MSTALL);
    nxt.req = 1'b1; nxt.ack = 1'b1; step("mstall_ack", E_RUN);
    step("mstall_after", E_RUN);
    nxt.ack = 1'b1; step("ack_no_req", E_RUN);

    nxt.trap = 1'b1; step("trap", E_TRAP);
    nxt.br = 1'b1; nxt.if_busy = 1'b1; step("drain_1", E_DRAIN);
    nxt.load = 1'b1; nxt.rd = 5'd3; nxt.rd_en = 1'b1; nxt.rs1 = 5'd3; nxt.rs1_en = 1'b1;
    step("drain_2", E_DRAIN);
    step("drain_done", E_RUN);

    nxt.br = 1'b1; nxt.load = 1'b1; nxt.rd = 5'd8; nxt.rd_en = 1'b1; nxt.rs2 = 5'd8; nxt.rs2_en = 1'b1;
    step("br_over_lu", E_BR);
    nxt.br = 1'b1; nxt.if_busy = 1'b1; step("br_over_ifb", E_BR);

    nxt.req = 1'b1; nxt.br = 1'b1; step("stall_over_br", E_MSTALL);
    nxt.req = 1'b1; nxt.trap = 1'b1; step("stall_over_trap", E_MSTALL);
    nxt.req = 1'b1; nxt.ack = 1'b1; nxt.br = 1'b1; step("br_after_ack", E_BR);
    step("post_br", E_RUN);

    nxt.req = 1'b1; step("pre_rst_stall", E_MSTALL);
    nxt.rst = 1'b1; nxt.req = 1'b1; step("rst_in_wait", E_RST);
    step("run_after_rst", E_RUN);
    nxt.trap = 1'b1; step("trap_2", E_TRAP);
    nxt.rst = 1'b1; step("rst_in_drain", E_RST);
    step("run_after_rst2", E_RUN);
    nxt.req = 1'b1; nxt.ack = 1'b1; nxt.trap = 1'b1; step("trap_on_ack", E_TRAP);
    step("drain_3", E_DRAIN);
    step("drain_4", E_DRAIN);
    step("final_run", E_RUN);
    step("final_idle", E_RUN);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. Drives the per-register flow/flush pairs (inst_valid_i / ex_flush_i) of if2id, id2ex, ex2mem and mem2wb. It resolves four hazard sources and sequences post-trap draining with a small state machine:
- fetch-busy
- load-use
- data-memory wait
- EX branch redirect
Each pipeline register loads when valid=1, loads a bubble when valid=1 & flush=1, and holds when valid=0.

Parameters:
TRAP_DRAIN_CYCLES, 2, cycles after a trap redirect during which IF/ID/EX registers stay flushed (CSR writeback settling); legal range 1..15
PERF_W, 32, width of the performance counters (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_busy_i  in  1  fetch has no instruction this cycle
id_rs1_index_i  in  5  ID source 1 index
id_rs1_en_i  in  1  ID source 1 used
id_rs2_index_i  in  5  ID source 2 index
id_rs2_en_i  in  1  ID source 2 used
ex_rd_index_i  in  5  EX destination index
ex_rd_en_i  in  1  EX writes rd
ex_inst_load_i  in  1  EX instruction is a load
ex_branch_taken_i  in  1  EX resolved a taken branch/jump
mem_req_i  in  1  MEM stage has an outstanding data access (level)
mem_ack_i  in  1  data access completes this cycle (pulse)
mem_trap_i  in  1  MEM holds ecall/ebreak/mret/trap
if2id_valid_o, id2ex_valid_o, ex2mem_valid_o, mem2wb_valid_o  out  1 each  flow enables
if2id_flush_o, id2ex_flush_o, ex2mem_flush_o, mem2wb_flush_o  out  1 each  flush requests
pc_hold_o  out  1  PC must not advance
pc_redirect_o  out  2  0 none, 1 branch target, 2 trap vector/mepc
mem_wait_o  out  1  FSM in MEM_WAIT

Behaviour:
- All outputs are combinational from FSM state and current inputs. There is no added latency; decisions take effect at the next clk edge.
- While rst is asserted: state=RUN, drain counter=0, all valid_o=0, all flush_o=0, pc_hold_o=1, pc_redirect_o=0, mem_wait_o=0.
- Default (no hazard): all valid=1, flush=0, pc_hold=0, redirect=0.
- Hazard conditions, in strict priority order (highest first):
  1. mem_stall = mem_req_i & ~mem_ack_i
     - if2id/id2ex/ex2mem valid=0 (hold); mem2wb valid=1, flush=1 (bubble); pc_hold=1.
     - Trap, branch and load-use are ignored this cycle; they re-evaluate once the stall releases.
  2. mem_trap_i (not mem_stall)
     - if2id/id2ex/ex2mem valid=1, flush=1; mem2wb flows.
     - redirect=2.
     - State goes to TRAP_DRAIN with counter loaded to TRAP_DRAIN_CYCLES-1.
  3. ex_branch_taken_i
     - if2id/id2ex valid=1, flush=1; ex2mem/mem2wb flow.
     - redirect=1.
  4. load_use = ex_inst_load_i & ex_rd_en_i & ex_rd_index_i!=0 & ((id_rs1_en_i & rs1==rd) | (id_rs2_en_i & rs2==rd))
     - if2id valid=0; id2ex valid=1, flush=1; ex2mem/mem2wb flow; pc_hold=1.
  5. if_busy_i
     - if2id valid=1, flush=1; others flow; pc_hold=1.
- FSM states: RUN, MEM_WAIT, TRAP_DRAIN.
  - RUN -> MEM_WAIT on mem_stall.
  - MEM_WAIT -> RUN in the cycle mem_ack_i=1; the ack cycle flows normally under the rules above.
  - RUN -> TRAP_DRAIN on trap.
  - In TRAP_DRAIN: if2id/id2ex/ex2mem valid=1, flush=1; mem2wb flows; pc_hold=0; redirect=0; branch, load-use and if_busy are ignored.
  - The counter decrements each cycle; TRAP_DRAIN -> RUN when counter==0.
  - With TRAP_DRAIN_CYCLES=1 the FSM returns to RUN on the next cycle.
- mem_ack_i without mem_req_i is ignored.
- mem_trap_i during TRAP_DRAIN is impossible by construction; if it occurs, the counter reloads.
- rst mid-MEM_WAIT or mid-TRAP_DRAIN returns immediately to RUN with the counter cleared.

Optional Feature:
PIPE_CTRL_PERF_EN defined adds the following outputs, each PERF_W bits, reset to 0 and wrapping modulo 2^PERF_W:
- stall_cycles_o: +1 on each mem_stall or load_use cycle
- flush_events_o: +1 on each trap or branch redirect
Undefined: these ports and their counters do not exist, and the core behaviour is identical.

Decomposition:
- Shared defines: REG_INDEX_BUS width, FSM state encodings (2-bit), pc_redirect encodings.
- One natural sub-module: pipe_hazard_detect, the combinational load-use comparator. The FSM and counter stay in pipe_ctrl.

Test Plan:
- Reset released, no hazards -> all four valid=1, all flush=0, pc_hold=0, redirect=0.
- ex_inst_load=1, ex_rd=5, ex_rd_en=1, id_rs2=5, id_rs2_en=1 -> if2id valid=0, id2ex valid=1 flush=1, pc_hold=1. Repeat with ex_rd=0 -> no stall.
- mem_req=1 for 3 cycles, ack on the 3rd -> cycles 1-2: mem_wait_o=1, mem2wb flush=1, upper registers hold. Cycle 3: all flow; state RUN next cycle.
- mem_trap=1 with TRAP_DRAIN_CYCLES=2 -> trap cycle has redirect=2 and 3 upper flushes, then exactly 2 more flush cycles, then RUN.
- Branch and load-use together -> branch wins: if2id/id2ex flushed, pc_hold=0, redirect=1.
- mem_stall together with branch -> stall wins and branch is deferred; after ack, branch (still asserted) flushes with redirect=1. With PIPE_CTRL_PERF_EN defined, stall_cycles_o and flush_events_o increment accordingly.
